// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: reads the PC, fetches over MEM_REQ/MEM_ACK into a one-entry IR,
// and steps or redirects the PC. Optional memory timeout is enabled by FETCH_TIMEOUT_EN.
module instr_fetch_unit #(
  parameter int AW = 5,
  parameter int IW = 16
`ifdef FETCH_TIMEOUT_EN
  , parameter int TIMEOUT = 15
`endif
) (
  input  logic          CLOCK,
  input  logic          RESET,
  input  logic          RUN,
  input  logic [AW-1:0] PC_COUNT,
  output logic          PC_ENABLE,
  output logic          PC_LOAD,
  output logic [AW-1:0] PC_DATA,
  output logic          MEM_REQ,
  output logic [AW-1:0] MEM_ADDR,
  input  logic          MEM_ACK,
  input  logic [IW-1:0] MEM_RDATA,
  output logic [IW-1:0] IR,
  output logic [AW-1:0] IR_PC,
  output logic          IR_VALID,
  input  logic          IR_READY,
  input  logic          BR_TAKEN,
  input  logic [AW-1:0] BR_TARGET,
  output logic          BUSY,
  output logic          FETCH_ERR,
  output logic [1:0]    DBG_STATE
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_FETCH    = 2'd1,
    S_WAIT_DEC = 2'd2,
    S_FLUSH    = 2'd3
  } state_t;

  state_t          state_q;
  logic            mem_req_q;
  logic [AW-1:0]   mem_addr_q;
  logic [IW-1:0]   ir_q;
  logic [AW-1:0]   ir_pc_q;
  logic            ir_valid_q;

  logic            ack;
  logic            run_ok;
  logic            tmo_fire;
  logic [AW-1:0]   next_addr;

  // Handshakes: MEM_ACK counts only while MEM_REQ is high, and MEM_REQ/MEM_ADDR hold until it
  // arrives. IR moves to the decoder on a cycle with IR_VALID & IR_READY; otherwise IR/IR_PC hold.
  assign ack       = mem_req_q & MEM_ACK;
  assign run_ok    = RUN & ~FETCH_ERR;
  // On a redirect cycle the PC only holds the target after this edge, so fetch from it directly.
  assign next_addr = BR_TAKEN ? BR_TARGET : PC_COUNT;

  assign PC_LOAD   = BR_TAKEN;
  assign PC_ENABLE = BR_TAKEN | ((state_q == S_FETCH) & ack);
  assign PC_DATA   = BR_TARGET;

  assign MEM_REQ   = mem_req_q;
  assign MEM_ADDR  = mem_addr_q;
  assign IR        = ir_q;
  assign IR_PC     = ir_pc_q;
  assign IR_VALID  = ir_valid_q;
  assign BUSY      = (state_q != S_IDLE);
  assign DBG_STATE = state_q;

`ifdef FETCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] timer_q;
  logic          fetch_err_q;

  // A redirect out of FETCH without ack restarts the wait in FLUSH, so it never times out here.
  assign tmo_fire = mem_req_q & ~MEM_ACK & ~((state_q == S_FETCH) & BR_TAKEN)
                  & (timer_q == TW'(TIMEOUT - 1));

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      timer_q     <= '0;
      fetch_err_q <= 1'b0;
    end else begin
      if (tmo_fire) begin
        fetch_err_q <= 1'b1;
      end
      if (!mem_req_q || MEM_ACK || ((state_q == S_FETCH) && BR_TAKEN)) begin
        timer_q <= '0;
      end else begin
        timer_q <= timer_q + 1'b1;
      end
    end
  end

  assign FETCH_ERR = fetch_err_q;
`else
  assign tmo_fire  = 1'b0;
  assign FETCH_ERR = 1'b0;
`endif

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= S_IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      ir_q       <= '0;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (run_ok) begin
            state_q    <= S_FETCH;
            mem_req_q  <= 1'b1;
            mem_addr_q <= next_addr;
          end
        end
        S_FETCH: begin
          if (BR_TAKEN) begin
            if (!ack) begin
              state_q <= S_FLUSH;
            end else if (run_ok) begin
              mem_addr_q <= BR_TARGET;
            end else begin
              state_q   <= S_IDLE;
              mem_req_q <= 1'b0;
            end
          end else if (ack) begin
            ir_q       <= MEM_RDATA;
            ir_pc_q    <= mem_addr_q;
            ir_valid_q <= 1'b1;
            mem_req_q  <= 1'b0;
            state_q    <= S_WAIT_DEC;
          end else if (tmo_fire) begin
            state_q   <= S_IDLE;
            mem_req_q <= 1'b0;
          end
        end
        S_WAIT_DEC: begin
          if (BR_TAKEN || IR_READY) begin
            ir_valid_q <= 1'b0;
            if (run_ok) begin
              state_q    <= S_FETCH;
              mem_req_q  <= 1'b1;
              mem_addr_q <= next_addr;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        S_FLUSH: begin
          if (ack) begin
            if (run_ok) begin
              state_q    <= S_FETCH;
              mem_addr_q <= next_addr;
            end else begin
              state_q   <= S_IDLE;
              mem_req_q <= 1'b0;
            end
          end else if (tmo_fire) begin
            state_q   <= S_IDLE;
            mem_req_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: table of single fetches plus hand-written
// sequences for streaming, redirects, reset and the optional FETCH_TIMEOUT_EN timeout.
module tb_instr_fetch_unit;
  localparam int AW = 5;
  localparam int IW = 16;

  logic          CLOCK;
  logic          RESET;
  logic          RUN;
  logic [AW-1:0] PC_COUNT;
  logic          PC_ENABLE;
  logic          PC_LOAD;
  logic [AW-1:0] PC_DATA;
  logic          MEM_REQ;
  logic [AW-1:0] MEM_ADDR;
  logic          MEM_ACK;
  logic [IW-1:0] MEM_RDATA;
  logic [IW-1:0] IR;
  logic [AW-1:0] IR_PC;
  logic          IR_VALID;
  logic          IR_READY;
  logic          BR_TAKEN;
  logic [AW-1:0] BR_TARGET;
  logic          BUSY;
  logic          FETCH_ERR;
  logic [1:0]    DBG_STATE;

  instr_fetch_unit dut (
    .CLOCK(CLOCK), .RESET(RESET), .RUN(RUN), .PC_COUNT(PC_COUNT),
    .PC_ENABLE(PC_ENABLE), .PC_LOAD(PC_LOAD), .PC_DATA(PC_DATA),
    .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR), .MEM_ACK(MEM_ACK), .MEM_RDATA(MEM_RDATA),
    .IR(IR), .IR_PC(IR_PC), .IR_VALID(IR_VALID), .IR_READY(IR_READY),
    .BR_TAKEN(BR_TAKEN), .BR_TARGET(BR_TARGET), .BUSY(BUSY), .FETCH_ERR(FETCH_ERR),
    .DBG_STATE(DBG_STATE)
  );

  // ---------------- clock / reset ----------------
  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- bench state ----------------
  int            n_checks = 0;
  int            n_err = 0;
  logic [AW-1:0] pc;
  int            n_en;
  int            n_ld;
  bit            auto_mem;
  int            ack_delay;
  int            req_age;
  int            lat;
  int            cnt;
  int            got;
  logic [IW-1:0] t1_ir [3];

  typedef struct {
    logic [AW-1:0] start_pc;
    int            ack_dly;
    int            hold;
    logic [IW-1:0] exp_ir;
    logic [AW-1:0] exp_next;
    int            exp_lat;
  } fvec_t;

  fvec_t vecs [4];

  function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
    return {3'b101, a, a, 3'b011};
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_pc(input logic [AW-1:0] v);
    pc = v;
    PC_COUNT = v;
  endtask

  // One clock: memory responder + PC register model; returns at posedge + 1.
  task automatic cycle();
    logic          prev_req;
    logic          prev_ack;
    logic          en_s;
    logic          ld_s;
    logic [AW-1:0] d_s;
    prev_req = MEM_REQ;
    if (auto_mem) begin
      MEM_ACK = MEM_REQ && (req_age == ack_delay);
      if (MEM_REQ) MEM_RDATA = mem_word(MEM_ADDR);
    end
    prev_ack = MEM_ACK;
    @(negedge CLOCK);
    en_s = PC_ENABLE;
    ld_s = PC_LOAD;
    d_s  = PC_DATA;
    if (en_s) n_en++;
    if (ld_s) n_ld++;
    @(posedge CLOCK);
    #1;
    if (en_s) pc = ld_s ? d_s : pc + 1'b1;
    PC_COUNT = pc;
    if (!MEM_REQ || prev_ack || !prev_req) req_age = 0;
    else req_age++;
  endtask

  task automatic wait_ir_valid(input string name);
    lat = 0;
    while (!IR_VALID && lat < 40) begin
      cycle();
      lat++;
    end
    if (!IR_VALID) chk({name, "_timeout"}, 32'(IR_VALID), 32'd1);
  endtask

  task automatic consume();
    IR_READY = 1'b1;
    cycle();
    IR_READY = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    RESET = 1'b0; RUN = 1'b0; PC_COUNT = '0; MEM_ACK = 1'b0; MEM_RDATA = '0;
    IR_READY = 1'b0; BR_TAKEN = 1'b0; BR_TARGET = '0;
    pc = '0; n_en = 0; n_ld = 0; auto_mem = 1'b1; ack_delay = 0; req_age = 0;
    t1_ir[0] = 16'hA003; t1_ir[1] = 16'hA10B; t1_ir[2] = 16'hA213;
    vecs[0] = '{5'd0,  0, 0, 16'hA003, 5'd1, 2};
    vecs[1] = '{5'd7,  1, 5, 16'hA73B, 5'd8, 3};
    vecs[2] = '{5'd31, 3, 2, 16'hBFFB, 5'd0, 5};
    vecs[3] = '{5'd5,  2, 1, 16'hA52B, 5'd6, 4};

    // reset values
    repeat (2) @(posedge CLOCK);
    #1;
    chk("rst_mem_req",  32'(MEM_REQ),   32'd0);
    chk("rst_mem_addr", 32'(MEM_ADDR),  32'd0);
    chk("rst_ir",       32'(IR),        32'd0);
    chk("rst_ir_pc",    32'(IR_PC),     32'd0);
    chk("rst_ir_valid", 32'(IR_VALID),  32'd0);
    chk("rst_busy",     32'(BUSY),      32'd0);
    chk("rst_fetch_err",32'(FETCH_ERR), 32'd0);
    chk("rst_state",    32'(DBG_STATE), 32'd0);
    chk("rst_pc_en",    32'(PC_ENABLE), 32'd0);
    RESET = 1'b1;
    cycle();
    cycle();
    chk("idle_busy", 32'(BUSY), 32'd0);

    // stray ack while idle is ignored
    auto_mem = 1'b0;
    MEM_ACK = 1'b1; MEM_RDATA = 16'hFFFF;
    cycle();
    MEM_ACK = 1'b0;
    auto_mem = 1'b1;
    chk("stray_ack_valid", 32'(IR_VALID), 32'd0);
    chk("stray_ack_ir",    32'(IR),       32'd0);
    chk("stray_ack_pc_en", 32'(n_en),     32'd0);

    // streaming fetch from PC 0
    set_pc(5'd0); ack_delay = 1; req_age = 0; n_en = 0; n_ld = 0;
    IR_READY = 1'b1; RUN = 1'b1; got = 0;
    for (int c = 0; c < 60 && got < 3; c++) begin
      cycle();
      if (IR_VALID) begin
        chk($sformatf("stream_ir%0d", got),    32'(IR),    32'(t1_ir[got]));
        chk($sformatf("stream_ir_pc%0d", got), 32'(IR_PC), got);
        got++;
      end
    end
    chk("stream_count", got, 3);
    chk("stream_pc_en", n_en, 3);
    chk("stream_pc_ld", n_ld, 0);
    RUN = 1'b0;
    cycle();
    IR_READY = 1'b0;
    chk("stream_idle", 32'(BUSY), 32'd0);

    // table of single fetches with decoder back-pressure
    for (int i = 0; i < 4; i++) begin
      set_pc(vecs[i].start_pc); ack_delay = vecs[i].ack_dly; req_age = 0;
      n_en = 0; n_ld = 0; IR_READY = 1'b0; RUN = 1'b1;
      wait_ir_valid($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
      chk($sformatf("vec%0d_ir", i),      32'(IR),       32'(vecs[i].exp_ir));
      chk($sformatf("vec%0d_ir_pc", i),   32'(IR_PC),    32'(vecs[i].start_pc));
      chk($sformatf("vec%0d_pc", i),      32'(PC_COUNT), 32'(vecs[i].exp_next));
      repeat (vecs[i].hold) cycle();
      chk($sformatf("vec%0d_hold_ir", i),    32'(IR),      32'(vecs[i].exp_ir));
      chk($sformatf("vec%0d_hold_ir_pc", i), 32'(IR_PC),   32'(vecs[i].start_pc));
      chk($sformatf("vec%0d_hold_req", i),   32'(MEM_REQ), 32'd0);
      chk($sformatf("vec%0d_pc_en", i),      n_en, 1);
      chk($sformatf("vec%0d_pc_ld", i),      n_ld, 0);
      consume();
      chk($sformatf("vec%0d_next_req", i),  32'(MEM_REQ),  32'd1);
      chk($sformatf("vec%0d_next_addr", i), 32'(MEM_ADDR), 32'(vecs[i].exp_next));
      chk($sformatf("vec%0d_ir_drop", i),   32'(IR_VALID), 32'd0);
      RUN = 1'b0;
      wait_ir_valid($sformatf("vec%0d_drain", i));
      chk($sformatf("vec%0d_drain_ir_pc", i), 32'(IR_PC), 32'(vecs[i].exp_next));
      chk($sformatf("vec%0d_drain_ir", i),    32'(IR),    32'(mem_word(vecs[i].exp_next)));
      consume();
      chk($sformatf("vec%0d_idle", i), 32'(BUSY), 32'd0);
    end

    // redirect while a fetch is outstanding
    set_pc(5'd3); ack_delay = 3; req_age = 0; n_en = 0; n_ld = 0; RUN = 1'b1;
    cycle();
    cycle();
    chk("br_wait_addr", 32'(MEM_ADDR), 32'd3);
    BR_TAKEN = 1'b1; BR_TARGET = 5'h1A;
    cycle();
    BR_TAKEN = 1'b0;
    chk("br_wait_ld",     n_ld, 1);
    chk("br_wait_en",     n_en, 1);
    chk("br_wait_state",  32'(DBG_STATE), 32'd3);
    chk("br_wait_req",    32'(MEM_REQ),   32'd1);
    chk("br_wait_hold",   32'(MEM_ADDR),  32'd3);
    chk("br_wait_pc",     32'(PC_COUNT),  32'h1A);
    wait_ir_valid("br_wait");
    chk("br_wait_ir",     32'(IR),    32'hBAD3);
    chk("br_wait_ir_pc",  32'(IR_PC), 32'h1A);
    chk("br_wait_en_tot", n_en, 2);
    chk("br_wait_ld_tot", n_ld, 1);
    RUN = 1'b0;
    consume();

    // redirect coincident with ack
    set_pc(5'd8); auto_mem = 1'b0; n_en = 0; n_ld = 0; RUN = 1'b1;
    cycle();
    MEM_ACK = 1'b1; MEM_RDATA = 16'hDEAD; BR_TAKEN = 1'b1; BR_TARGET = 5'h11;
    cycle();
    MEM_ACK = 1'b0; BR_TAKEN = 1'b0;
    chk("br_ack_valid", 32'(IR_VALID), 32'd0);
    chk("br_ack_req",   32'(MEM_REQ),  32'd1);
    chk("br_ack_addr",  32'(MEM_ADDR), 32'h11);
    chk("br_ack_pc",    32'(PC_COUNT), 32'h11);
    chk("br_ack_en",    n_en, 1);
    chk("br_ack_ld",    n_ld, 1);
    RUN = 1'b0; auto_mem = 1'b1; ack_delay = 0; req_age = 0;
    wait_ir_valid("br_ack");
    chk("br_ack_ir_pc", 32'(IR_PC), 32'h11);
    chk("br_ack_ir",    32'(IR),    32'hB18B);
    consume();

    // asynchronous reset in the middle of a fetch
    set_pc(5'd9); ack_delay = 255; req_age = 0; RUN = 1'b1;
    cycle();
    cycle();
    chk("rst_mid_busy_pre", 32'(BUSY), 32'd1);
    RESET = 1'b0;
    #1;
    chk("rst_mid_req",   32'(MEM_REQ),  32'd0);
    chk("rst_mid_valid", 32'(IR_VALID), 32'd0);
    chk("rst_mid_busy",  32'(BUSY),     32'd0);
    cycle();
    RESET = 1'b1; ack_delay = 0; req_age = 0;
    cycle();
    chk("rst_rel_req",  32'(MEM_REQ),  32'd1);
    chk("rst_rel_addr", 32'(MEM_ADDR), 32'd9);
    RUN = 1'b0;
    wait_ir_valid("rst_rel");
    chk("rst_rel_ir_pc", 32'(IR_PC), 32'd9);
    consume();

    // memory never answers
    set_pc(5'd4); ack_delay = 1000; req_age = 0; n_en = 0; n_ld = 0; RUN = 1'b1;
    cycle();
`ifdef FETCH_TIMEOUT_EN
    cnt = 0;
    while (MEM_REQ && cnt < 40) begin
      cycle();
      cnt++;
    end
    chk("tmo_cycles", cnt, 15);
    chk("tmo_err",    32'(FETCH_ERR), 32'd1);
    chk("tmo_busy",   32'(BUSY),      32'd0);
    chk("tmo_valid",  32'(IR_VALID),  32'd0);
    repeat (3) cycle();
    chk("tmo_run_ignored", 32'(MEM_REQ), 32'd0);
    BR_TAKEN = 1'b1; BR_TARGET = 5'h13;
    cycle();
    BR_TAKEN = 1'b0;
    chk("tmo_br_pc",   32'(PC_COUNT), 32'h13);
    chk("tmo_br_ld",   n_ld, 1);
    chk("tmo_br_busy", 32'(BUSY), 32'd0);
`else
    repeat (20) cycle();
    chk("noack_req",  32'(MEM_REQ),   32'd1);
    chk("noack_addr", 32'(MEM_ADDR),  32'd4);
    chk("noack_err",  32'(FETCH_ERR), 32'd0);
    chk("noack_busy", 32'(BUSY),      32'd1);
`endif
    RUN = 1'b0;
    RESET = 1'b0;
    cycle();
    RESET = 1'b1;
    cycle();
    chk("final_err", 32'(FETCH_ERR), 32'd0);
    chk("final_req", 32'(MEM_REQ),   32'd0);

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
